fastica_sequencer: RTL and testbench

Parametrised next-generation top-level sequencer for the FastICA processor. Drives orthogonalisation, normalisation, fixed-point update, error check and result write-back for `N_COMP` components in deflation or symmetric mode. Bounds iteration count per component and streams a `MEM_LEN`-word write-back with an explicit address. Sits between the host `go_fastica` level and the symm/norm/fast/error/mul1/mem1 sub-blocks.

---
 rtl/fastica_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_fastica_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fastica_sequencer.sv
// FastICA top-level sequencer.
// Walks each independent component through orthogonalisation, normalisation,
// fixed-point update and convergence check, then streams a MEM_LEN-word
// write-back. Deflation mode processes N_COMP components one after another;
// symmetric mode makes a single pass that covers all components at once.
// go_fastica doubles as the asynchronous active-low reset: dropping it aborts
// the run immediately from any state.
// Every output comes straight from a flop. Each strobe flop is loaded with
// the decode of the next state, so a strobe is aligned with the state it
// belongs to.
module fastica_sequencer #(
    parameter int N_COMP   = 4,
    parameter int COMP_W   = 2,
    parameter int MAX_ITER = 64,
    parameter int ITER_W   = 7,
    parameter int MEM_LEN  = 128,
    parameter int MEM_W    = 7
) (
    input  logic              clk_fastica,
    input  logic              go_fastica,
    input  logic              mode_symm,
    input  logic              symm_busy,
    input  logic              fast_busy,
    input  logic              error_busy,
    output logic              fastica_busy,
    output logic              go_symm,
    output logic              en_norm,
    output logic              go_fast,
    output logic              en_error,
    output logic              en_mul1,
    output logic              en_mem1,
    output logic [COMP_W-1:0] comp_idx,
    output logic [ITER_W-1:0] iter_cnt,
    output logic [MEM_W-1:0]  mem_addr,
    output logic              done,
    output logic              timeout
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ORTH = 3'd1,
        ST_NORM = 3'd2,
        ST_FAST = 3'd3,
        ST_ERR  = 3'd4,
        ST_MUL  = 3'd5,
        ST_MEM  = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    localparam logic [COMP_W-1:0] COMP_LAST = COMP_W'(N_COMP - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);
    localparam logic [MEM_W-1:0]  MEM_LAST  = MEM_W'(MEM_LEN - 1);

    // Strobe bit order: {go_symm, en_norm, go_fast, en_error, en_mul1, en_mem1}
    function automatic logic [5:0] strobe_decode(input state_t st);
        logic [5:0] stb;
        case (st)
            ST_ORTH: stb = 6'b100000;
            ST_NORM: stb = 6'b010000;
            ST_FAST: stb = 6'b001000;
            ST_ERR:  stb = 6'b000100;
            ST_MUL:  stb = 6'b000010;
            ST_MEM:  stb = 6'b000011;
            default: stb = 6'b000000;
        endcase
        return stb;
    endfunction

    state_t            state_q, state_d;
    logic              fresh_q, fresh_d;      // first cycle spent in the current state
    logic              mode_q, mode_d;
    logic [COMP_W-1:0] comp_q, comp_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [MEM_W-1:0]  addr_q, addr_d;
    logic              timeout_q, timeout_d;
    logic [5:0]        strobe_q, strobe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state, counter and registered-output decode
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        comp_d    = comp_q;
        iter_d    = iter_q;
        addr_d    = addr_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                mode_d  = mode_symm;
                comp_d  = {COMP_W{1'b0}};
                iter_d  = {ITER_W{1'b0}};
                state_d = ST_ORTH;
            end
            ST_ORTH: begin
                // The entry cycle is the sub-block's grant cycle; busy is not yet valid.
                if (!fresh_q && !symm_busy) begin
                    state_d = ST_NORM;
                end else begin
                    state_d = ST_ORTH;
                end
            end
            ST_NORM: begin
                state_d = ST_FAST;
            end
            ST_FAST: begin
                if (!fresh_q && !fast_busy) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_FAST;
                end
            end
            ST_ERR: begin
                if (!error_busy) begin
                    state_d = ST_MUL;
                end else if (iter_q < ITER_LAST) begin
                    iter_d  = iter_q + ITER_W'(1'b1);
                    state_d = ST_ORTH;
                end else begin
                    // Iteration budget exhausted: flag it and write back anyway.
                    timeout_d = 1'b1;
                    state_d   = ST_MUL;
                end
            end
            ST_MUL: begin
                addr_d  = {MEM_W{1'b0}};
                state_d = ST_MEM;
            end
            ST_MEM: begin
                if (addr_q == MEM_LAST) begin
                    if (mode_q || (comp_q == COMP_LAST)) begin
                        state_d = ST_DONE;
                    end else begin
                        comp_d  = comp_q + COMP_W'(1'b1);
                        iter_d  = {ITER_W{1'b0}};
                        state_d = ST_ORTH;
                    end
                end else begin
                    addr_d  = addr_q + MEM_W'(1'b1);
                    state_d = ST_MEM;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        fresh_d  = (state_d != state_q);
        strobe_d = strobe_decode(state_d);
        busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d   = (state_d == ST_DONE);
    end

    // State, counters and output flops; go_fastica low clears everything at once
    always_ff @(posedge clk_fastica or negedge go_fastica) begin
        if (!go_fastica) begin
            state_q   <= ST_IDLE;
            fresh_q   <= 1'b0;
            mode_q    <= 1'b0;
            comp_q    <= {COMP_W{1'b0}};
            iter_q    <= {ITER_W{1'b0}};
            addr_q    <= {MEM_W{1'b0}};
            timeout_q <= 1'b0;
            strobe_q  <= 6'b000000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fresh_q   <= fresh_d;
            mode_q    <= mode_d;
            comp_q    <= comp_d;
            iter_q    <= iter_d;
            addr_q    <= addr_d;
            timeout_q <= timeout_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign {go_symm, en_norm, go_fast, en_error, en_mul1, en_mem1} = strobe_q;
    assign fastica_busy = busy_q;
    assign done         = done_q;
    assign timeout      = timeout_q;
    assign comp_idx     = comp_q;
    assign iter_cnt     = iter_q;
    assign mem_addr     = addr_q;

endmodule

// File: tb/tb_fastica_sequencer.sv
// Testbench for fastica_sequencer. A reference model expands a randomised
// plan of per-phase busy durations and convergence decisions into an
// expected cycle-by-cycle trace. The plan also provides the stimulus.
// Instance a uses the default parameters. Instance b is a small
// configuration: 2 components, 4 iterations, 1-word write-back.
module tb_fastica_sequencer;

    logic clk;
    int   checks;
    int   fails;

    // instance a (defaults)
    logic go_a, mode_a, sb_a, fb_a, eb_a;
    logic busy_a, go_symm_a, en_norm_a, go_fast_a, en_error_a, en_mul1_a, en_mem1_a;
    logic [1:0] comp_idx_a;
    logic [6:0] iter_cnt_a;
    logic [6:0] mem_addr_a;
    logic done_a, timeout_a;

    // instance b (N_COMP=2, MAX_ITER=4, MEM_LEN=1)
    logic go_b, mode_b, sb_b, fb_b, eb_b;
    logic busy_b, go_symm_b, en_norm_b, go_fast_b, en_error_b, en_mul1_b, en_mem1_b;
    logic [0:0] comp_idx_b;
    logic [1:0] iter_cnt_b;
    logic [0:0] mem_addr_b;
    logic done_b, timeout_b;

    fastica_sequencer dut_a (
        .clk_fastica (clk),        .go_fastica (go_a),      .mode_symm (mode_a),
        .symm_busy   (sb_a),       .fast_busy  (fb_a),      .error_busy (eb_a),
        .fastica_busy(busy_a),     .go_symm    (go_symm_a), .en_norm   (en_norm_a),
        .go_fast     (go_fast_a),  .en_error   (en_error_a),.en_mul1   (en_mul1_a),
        .en_mem1     (en_mem1_a),  .comp_idx   (comp_idx_a),.iter_cnt  (iter_cnt_a),
        .mem_addr    (mem_addr_a), .done       (done_a),    .timeout   (timeout_a)
    );

    fastica_sequencer #(
        .N_COMP(2), .COMP_W(1), .MAX_ITER(4), .ITER_W(2), .MEM_LEN(1), .MEM_W(1)
    ) dut_b (
        .clk_fastica (clk),        .go_fastica (go_b),      .mode_symm (mode_b),
        .symm_busy   (sb_b),       .fast_busy  (fb_b),      .error_busy (eb_b),
        .fastica_busy(busy_b),     .go_symm    (go_symm_b), .en_norm   (en_norm_b),
        .go_fast     (go_fast_b),  .en_error   (en_error_b),.en_mul1   (en_mul1_b),
        .en_mem1     (en_mem1_b),  .comp_idx   (comp_idx_b),.iter_cnt  (iter_cnt_b),
        .mem_addr    (mem_addr_b), .done       (done_b),    .timeout   (timeout_b)
    );

    always #5 clk = ~clk;

    // One cycle of the plan: expected outputs plus the inputs applied that cycle
    typedef struct {
        logic [5:0] stb;
        logic       bsy;
        logic       dn;
        logic       tmo;
        logic [7:0] comp;
        logic [7:0] iter;
        logic [7:0] addr;
        logic       mode;
        logic       sb;
        logic       fb;
        logic       eb;
    } rec_t;

    localparam logic [5:0] S_ORTH = 6'b100000;
    localparam logic [5:0] S_NORM = 6'b010000;
    localparam logic [5:0] S_FAST = 6'b001000;
    localparam logic [5:0] S_ERR  = 6'b000100;
    localparam logic [5:0] S_MUL  = 6'b000010;
    localparam logic [5:0] S_MEM  = 6'b000011;

    rec_t plan[$];
    int   m_comp, m_iter, m_addr;
    logic m_tmo;
    int   done_cyc, orth_cyc, orth_ent, peak_iter;

    function automatic rec_t mk(input logic [5:0] stb);
        rec_t r;
        r.stb  = stb;
        r.bsy  = (stb != 6'b000000);
        r.dn   = 1'b0;
        r.tmo  = m_tmo;
        r.comp = 8'(m_comp);
        r.iter = 8'(m_iter);
        r.addr = 8'(m_addr);
        r.mode = 1'($urandom_range(1, 0));
        r.sb   = 1'($urandom_range(1, 0));
        r.fb   = 1'($urandom_range(1, 0));
        r.eb   = 1'($urandom_range(1, 0));
        return r;
    endfunction

    function automatic logic [32:0] exp_vec(input rec_t r);
        return {r.stb, r.bsy, r.dn, r.tmo, r.comp, r.iter, r.addr};
    endfunction

    function automatic logic [32:0] obs(input int sel);
        if (sel == 0)
            return {go_symm_a, en_norm_a, go_fast_a, en_error_a, en_mul1_a, en_mem1_a,
                    busy_a, done_a, timeout_a, 8'(comp_idx_a), 8'(iter_cnt_a), 8'(mem_addr_a)};
        else
            return {go_symm_b, en_norm_b, go_fast_b, en_error_b, en_mul1_b, en_mem1_b,
                    busy_b, done_b, timeout_b, 8'(comp_idx_b), 8'(iter_cnt_b), 8'(mem_addr_b)};
    endfunction

    task automatic chk(input string tag, input logic [32:0] o, input logic [32:0] e);
        checks++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_int(input string tag, input int o, input int e);
        checks++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    // Expand the sequencing rules into an expected trace
    task automatic build_plan(input int n, input int mi, input int ml, input bit symm,
                              input int eb_pct, input int ok_lo, input int ok_hi,
                              input int fk_lo, input int fk_hi);
        rec_t r;
        int   k;
        int   len;
        bit   last_comp;
        bit   conv;
        plan.delete();
        m_comp = 0; m_iter = 0; m_addr = 0; m_tmo = 1'b0;
        r = mk(6'b000000);
        r.mode = symm;
        plan.push_back(r);
        last_comp = 1'b0;
        while (!last_comp) begin
            conv = 1'b0;
            while (!conv) begin
                k   = int'($urandom_range(ok_hi, ok_lo));
                len = (k + 1 > 2) ? k + 1 : 2;
                for (int i = 1; i <= len; i++) begin
                    r = mk(S_ORTH); r.sb = (i <= k); plan.push_back(r);
                end
                plan.push_back(mk(S_NORM));
                k   = int'($urandom_range(fk_hi, fk_lo));
                len = (k + 1 > 2) ? k + 1 : 2;
                for (int i = 1; i <= len; i++) begin
                    r = mk(S_FAST); r.fb = (i <= k); plan.push_back(r);
                end
                r = mk(S_ERR);
                r.eb = (int'($urandom_range(99, 0)) < eb_pct);
                plan.push_back(r);
                if (!r.eb) conv = 1'b1;
                else if (m_iter < mi - 1) m_iter++;
                else begin m_tmo = 1'b1; conv = 1'b1; end
            end
            plan.push_back(mk(S_MUL));
            for (int a = 0; a < ml; a++) begin
                m_addr = a;
                plan.push_back(mk(S_MEM));
            end
            if (symm || m_comp == n - 1) last_comp = 1'b1;
            else begin m_comp++; m_iter = 0; end
        end
        repeat (3) begin
            r = mk(6'b000000); r.dn = 1'b1; plan.push_back(r);
        end
    endtask

    task automatic set_go(input int sel, input logic v);
        if (sel == 0) go_a = v; else go_b = v;
    endtask

    task automatic drive(input int sel, input rec_t r);
        if (sel == 0) begin
            mode_a = r.mode; sb_a = r.sb; fb_a = r.fb; eb_a = r.eb;
        end else begin
            mode_b = r.mode; sb_b = r.sb; fb_b = r.fb; eb_b = r.eb;
        end
    endtask

    // Replay the plan; entered and left at #1 after a rising edge with go low
    task automatic run_plan(input int sel, input bit abort);
        rec_t        r;
        logic [32:0] o;
        logic        prev_gs;
        bit          aborted;
        done_cyc = -1; orth_cyc = 0; orth_ent = 0; peak_iter = 0;
        prev_gs = 1'b0; aborted = 1'b0;
        set_go(sel, 1'b1);
        for (int idx = 0; idx < plan.size(); idx++) begin
            r = plan[idx];
            drive(sel, r);
            o = obs(sel);
            chk("trace", o, exp_vec(r));
            if (o[25] && done_cyc < 0) done_cyc = idx;
            if (o[32]) orth_cyc++;
            if (o[32] && !prev_gs) orth_ent++;
            prev_gs = o[32];
            if (int'(o[15:8]) > peak_iter) peak_iter = int'(o[15:8]);
            if (abort && r.stb == S_MEM && r.addr == 8'd50) begin
                #1 set_go(sel, 1'b0);
                #1 chk("abort_async_clear", obs(sel), 33'h0);
                aborted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        set_go(sel, 1'b0);
        #1 chk("go_low_clear", obs(sel), 33'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        clk = 1'b0; checks = 0; fails = 0;
        go_a = 1'b0; mode_a = 1'b0; sb_a = 1'b0; fb_a = 1'b0; eb_a = 1'b0;
        go_b = 1'b0; mode_b = 1'b0; sb_b = 1'b0; fb_b = 1'b0; eb_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", obs(0), 33'h0);
        chk("reset_b", obs(1), 33'h0);

        // deflation, no busy, always converged: done 1 + 4*135 cycles after go
        build_plan(4, 64, 128, 1'b0, 0, 0, 0, 0, 0);
        run_plan(0, 1'b0);
        chk_int("done_cycle_deflation", done_cyc, 541);
        chk_int("orth_entries_deflation", orth_ent, 4);

        // symmetric: single pass
        build_plan(4, 64, 128, 1'b1, 0, 0, 0, 0, 0);
        run_plan(0, 1'b0);
        chk_int("done_cycle_symm", done_cyc, 136);
        chk_int("orth_entries_symm", orth_ent, 1);

        // symm_busy high for 10 cycles of every ORTH: 11 ORTH cycles each
        build_plan(4, 64, 128, 1'b0, 0, 10, 10, 0, 0);
        run_plan(0, 1'b0);
        chk_int("orth_cycles_busy10", orth_cyc, 44);
        chk_int("done_cycle_busy10", done_cyc, 577);

        // randomised busy lengths and convergence, both modes
        build_plan(4, 64, 128, 1'b0, 30, 0, 4, 0, 4);
        run_plan(0, 1'b0);
        build_plan(4, 64, 128, 1'b1, 30, 0, 4, 0, 4);
        run_plan(0, 1'b0);

        // abort during write-back at mem_addr 50, then a clean restart
        build_plan(4, 64, 128, 1'b0, 0, 0, 3, 0, 3);
        run_plan(0, 1'b1);
        build_plan(4, 64, 128, 1'b0, 20, 0, 2, 0, 2);
        run_plan(0, 1'b0);

        // never converges: 4 iterations per component, timeout, write-back still done
        build_plan(2, 4, 1, 1'b0, 100, 0, 2, 0, 2);
        run_plan(1, 1'b0);
        chk_int("peak_iter_timeout", peak_iter, 3);
        chk_int("orth_entries_timeout", orth_ent, 8);

        // small configuration, randomised, both modes
        build_plan(2, 4, 1, 1'b0, 50, 0, 3, 0, 3);
        run_plan(1, 1'b0);
        build_plan(2, 4, 1, 1'b1, 50, 0, 3, 0, 3);
        run_plan(1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
